// File: rtl/mcycle_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// controller states and the register-tag width.
package mcycle_unit_pkg;

  localparam int unsigned TAG_W       = 32'd4;
  localparam int unsigned OP_KIND_BIT = 32'd0;
  localparam int unsigned OP_SIGN_BIT = 32'd1;

  localparam logic OP_MUL    = 1'b0;
  localparam logic OP_DIV    = 1'b1;
  localparam logic OP_SIGNED = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } mcycleState_e;

  function automatic logic isDiv(input logic [1:0] op);
    return op[OP_KIND_BIT] == OP_DIV;
  endfunction

  function automatic logic isSigned(input logic [1:0] op);
    return op[OP_SIGN_BIT] == OP_SIGNED;
  endfunction

endpackage

// File: rtl/mcycle_signfix.sv
// Combinational sign correction applied to the magnitude results of the
// iteration datapath, so the datapath itself never deals with signs.
module mcycle_signfix
  import mcycle_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic             neg1,
  input  logic             neg2,
  input  logic             divZero,
  input  logic [WIDTH-1:0] rawLo,
  input  logic [WIDTH-1:0] rawHi,
  output logic [WIDTH-1:0] fixLo,
  output logic [WIDTH-1:0] fixHi
);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] negProd_s;
  logic [WIDTH-1:0]   negLo_s;
  logic [WIDTH-1:0]   negHi_s;
  logic               flip_s;

  assign prod_s    = {rawHi, rawLo};
  assign negProd_s = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
  assign negLo_s   = ~rawLo + {{(WIDTH-1){1'b0}}, 1'b1};
  assign negHi_s   = ~rawHi + {{(WIDTH-1){1'b0}}, 1'b1};
  assign flip_s    = neg1 ^ neg2;

  // Select final result halves from the magnitudes and operand signs.
  always_comb begin
    fixLo = rawLo;
    fixHi = rawHi;
    if (isDiv(op)) begin
      if (divZero) begin
        // Remainder is the dividend magnitude; restoring its sign returns Operand1 as-is.
        fixLo = {WIDTH{1'b1}};
        fixHi = neg1 ? negHi_s : rawHi;
      end else begin
        fixLo = flip_s ? negLo_s : rawLo;
        fixHi = neg1 ? negHi_s : rawHi;
      end
    end else begin
      {fixHi, fixLo} = flip_s ? negProd_s : prod_s;
    end
  end

endmodule

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit answering the Start/Busy handshake: one
// shift-add or restoring-divide step per cycle for WIDTH cycles.
module mcycle_unit
  import mcycle_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [TAG_W-1:0] WA3In,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic [TAG_W-1:0] MCycleWA3
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 32'sd1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  mcycleState_e     state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       op_r;
  logic             neg1_r;
  logic             neg2_r;
  logic             divZero_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] op2Mag_r;

  logic             startNeg1_s;
  logic             startNeg2_s;
  logic [WIDTH-1:0] mag1_s;
  logic [WIDTH-1:0] mag2_s;
  logic [WIDTH:0]   mulSum_s;
  logic [WIDTH:0]   divShift_s;
  logic [WIDTH:0]   divDiff_s;
  logic [WIDTH-1:0] nextHi_s;
  logic [WIDTH-1:0] nextLo_s;
  logic [WIDTH-1:0] fixLo_s;
  logic [WIDTH-1:0] fixHi_s;

  assign startNeg1_s = isSigned(MCycleOp) & Operand1[WIDTH-1];
  assign startNeg2_s = isSigned(MCycleOp) & Operand2[WIDTH-1];
  assign mag1_s      = startNeg1_s ? (~Operand1 + ONE) : Operand1;
  assign mag2_s      = startNeg2_s ? (~Operand2 + ONE) : Operand2;

  assign mulSum_s   = {1'b0, hi_r} + {1'b0, op2Mag_r};
  assign divShift_s = {hi_r, lo_r[WIDTH-1]};
  assign divDiff_s  = divShift_s - {1'b0, op2Mag_r};

  // One iteration step: hi/lo hold accumulator/multiplier or remainder/quotient.
  always_comb begin
    nextHi_s = hi_r;
    nextLo_s = lo_r;
    if (isDiv(op_r)) begin
      if (!divDiff_s[WIDTH]) begin
        nextHi_s = divDiff_s[WIDTH-1:0];
        nextLo_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        nextHi_s = divShift_s[WIDTH-1:0];
        nextLo_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (lo_r[0]) begin
        {nextHi_s, nextLo_s} = {mulSum_s, lo_r[WIDTH-1:1]};
      end else begin
        {nextHi_s, nextLo_s} = {1'b0, hi_r, lo_r[WIDTH-1:1]};
      end
    end
  end

  mcycle_signfix #(.WIDTH(WIDTH)) uSignfix (
    .op      (op_r),
    .neg1    (neg1_r),
    .neg2    (neg2_r),
    .divZero (divZero_r),
    .rawLo   (nextLo_s),
    .rawHi   (nextHi_s),
    .fixLo   (fixLo_s),
    .fixHi   (fixHi_s)
  );

  // Controller: handshake, iteration count and registered results.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      op_r      <= 2'b00;
      neg1_r    <= 1'b0;
      neg2_r    <= 1'b0;
      divZero_r <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      op2Mag_r  <= {WIDTH{1'b0}};
      Result1   <= {WIDTH{1'b0}};
      Result2   <= {WIDTH{1'b0}};
      Busy      <= 1'b0;
      Done      <= 1'b0;
      MCycleWA3 <= {TAG_W{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            state_r   <= COMPUTE;
            Busy      <= 1'b1;
            cnt_r     <= {CNT_W{1'b0}};
            op_r      <= MCycleOp;
            neg1_r    <= startNeg1_s;
            neg2_r    <= startNeg2_s;
            divZero_r <= isDiv(MCycleOp) && (Operand2 == {WIDTH{1'b0}});
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= mag1_s;
            op2Mag_r  <= mag2_s;
            MCycleWA3 <= WA3In;
          end else begin
            state_r <= IDLE;
            Busy    <= 1'b0;
          end
        end
        COMPUTE: begin
          hi_r  <= nextHi_s;
          lo_r  <= nextLo_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_CNT) begin
            state_r <= DONE;
            Result1 <= fixLo_s;
            Result2 <= fixHi_s;
            Busy    <= 1'b0;
            Done    <= 1'b1;
          end else begin
            state_r <= COMPUTE;
          end
        end
        default: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: directed vector table, hand-written
// handshake sequences and randomized operations against a 64-bit arithmetic model.
module tb_mcycle_unit;

  localparam int W = 32;

  logic          CLK;
  logic          RESETn;
  logic          Start;
  logic [1:0]    MCycleOp;
  logic [W-1:0]  Operand1;
  logic [W-1:0]  Operand2;
  logic [3:0]    WA3In;
  logic [W-1:0]  Result1;
  logic [W-1:0]  Result2;
  logic          Busy;
  logic          Done;
  logic [3:0]    MCycleWA3;

  int checkCount = 0;
  int passCount  = 0;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .Start     (Start),
    .MCycleOp  (MCycleOp),
    .Operand1  (Operand1),
    .Operand2  (Operand2),
    .WA3In     (WA3In),
    .Result1   (Result1),
    .Result2   (Result2),
    .Busy      (Busy),
    .Done      (Done),
    .MCycleWA3 (MCycleWA3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: returns {remainder/high, quotient/low} from plain 64-bit arithmetic.
  function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    if (op[0] == 1'b0) begin
      if (op[1]) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end else begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = ua * ub;
      end
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op[1]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Issue one op at the current negedge; returns at the negedge of the Done cycle.
  task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag,
                       input logic [31:0] e1, input logic [31:0] e2, input bit poke);
    int bad;
    bad = 0;
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b; WA3In = tag;
    @(posedge CLK);
    #1 Start = 1'b0;
    for (int i = 1; i <= W; i++) begin
      @(negedge CLK);
      if (!(Busy === 1'b1 && Done === 1'b0)) bad++;
      if (poke && i == 5) begin
        Start = 1'b1; MCycleOp = ~op; Operand1 = $urandom; Operand2 = $urandom; WA3In = ~tag;
      end
      if (poke && i == 8) Start = 1'b0;
    end
    check({name, ".busyWindow"}, 64'(bad), 64'd0);
    @(negedge CLK);
    check({name, ".done"}, {62'd0, Done, Busy}, {62'd0, 1'b1, 1'b0});
    check({name, ".result"}, {Result2, Result1}, {e2, e1});
    check({name, ".tag"}, 64'(MCycleWA3), 64'(tag));
  endtask

  task automatic idleStep(input string name, input logic [31:0] e1, input logic [31:0] e2);
    @(negedge CLK);
    check({name, ".pulse"}, {62'd0, Done, Busy}, 64'd0);
    check({name, ".hold"}, {Result2, Result1}, {e2, e1});
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [3:0]  rtag;
    logic [63:0] exp;
    int doneSeen;

    RESETn = 1'b0; Start = 1'b0; MCycleOp = 2'b00;
    Operand1 = 32'd0; Operand2 = 32'd0; WA3In = 4'd0;

    vecs[0]  = '{2'b00, 32'd7,          32'd6,          4'd5,  32'd42,         32'd0};
    vecs[1]  = '{2'b10, 32'hFFFF_FFFD,  32'd5,          4'd1,  32'hFFFF_FFF1,  32'hFFFF_FFFF};
    vecs[2]  = '{2'b01, 32'd100,        32'd7,          4'd2,  32'd14,         32'd2};
    vecs[3]  = '{2'b11, 32'hFFFF_FFF9,  32'd2,          4'd3,  32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[4]  = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  4'd4,  32'h8000_0000,  32'd0};
    vecs[5]  = '{2'b01, 32'd123,        32'd0,          4'd6,  32'hFFFF_FFFF,  32'd123};
    vecs[6]  = '{2'b11, 32'hFFFF_FFF9,  32'd0,          4'd7,  32'hFFFF_FFFF,  32'hFFFF_FFF9};
    vecs[7]  = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd8,  32'd1,          32'hFFFF_FFFE};
    vecs[8]  = '{2'b10, 32'h8000_0000,  32'h8000_0000,  4'd9,  32'd0,          32'h4000_0000};
    vecs[9]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  4'd10, 32'd0,          32'h8000_0000};
    vecs[10] = '{2'b11, 32'd7,          32'hFFFF_FFFE,  4'd11, 32'hFFFF_FFFD,  32'd1};
    vecs[11] = '{2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd12, 32'd1,          32'd0};

    repeat (3) @(negedge CLK);
    check("reset.results", {Result2, Result1}, 64'd0);
    check("reset.flags", {62'd0, Done, Busy}, 64'd0);
    check("reset.tag", 64'(MCycleWA3), 64'd0);
    RESETn = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 12; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag,
            vecs[i].e1, vecs[i].e2, 1'b0);
      idleStep($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2);
    end

    // Back-to-back: second Start issued in the Done cycle of the first.
    runOp("b2bFirst", 2'b00, 32'd9, 32'd9, 4'd13, 32'd81, 32'd0, 1'b0);
    runOp("b2bSecond", 2'b01, 32'd50, 32'd8, 4'd14, 32'd6, 32'd2, 1'b0);
    idleStep("b2bSecond", 32'd6, 32'd2);
    repeat (3) @(negedge CLK);
    check("holdIdle", {Result2, Result1, 28'd0, MCycleWA3}, {32'd2, 32'd6, 28'd0, 4'd14});

    // Start re-asserted with new operands while busy must be ignored.
    runOp("ignoreBusy", 2'b11, 32'hFFFF_FF9C, 32'd7, 4'd15, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b1);
    idleStep("ignoreBusy", 32'hFFFF_FFF2, 32'hFFFF_FFFE);

    // Reset asserted in the middle of an operation aborts it.
    doneSeen = 0;
    Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd11; Operand2 = 32'd13; WA3In = 4'd9;
    @(posedge CLK);
    #1 Start = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (Done !== 1'b0) doneSeen++;
    end
    RESETn = 1'b0;
    @(negedge CLK);
    check("abort.flags", {62'd0, Done, Busy}, 64'd0);
    check("abort.results", {Result2, Result1}, 64'd0);
    check("abort.tag", 64'(MCycleWA3), 64'd0);
    RESETn = 1'b1;
    repeat (40) begin
      @(negedge CLK);
      if (Done !== 1'b0 || Busy !== 1'b0) doneSeen++;
    end
    check("abort.noDone", 64'(doneSeen), 64'd0);

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      rop  = 2'($urandom_range(0, 3));
      ra   = $urandom;
      rb   = $urandom;
      rtag = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      exp = refModel(rop, ra, rb);
      runOp($sformatf("rand%0d", n), rop, ra, rb, rtag, exp[31:0], exp[63:32], 1'b0);
      if ($urandom_range(0, 1) == 1) idleStep($sformatf("rand%0d", n), exp[31:0], exp[63:32]);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
Iterative multi-cycle multiply/divide execution unit. It is the responder on the MCycle start/busy handshake that the pipeline hazard logic drives and observes. It accepts a start request from the Execute stage and holds Busy while computing. It returns a 2×WIDTH-bit result with the destination register tag, so the hazard logic can stall dependent instructions.

Parameters:
WIDTH, 32, operand width in bits; also the number of iteration cycles.

Ports:
CLK  input  1  clock; all state updates on rising edge
RESETn  input  1  synchronous, active-low reset
Start  input  1  request; sampled only when not Busy
MCycleOp  input  2  bit0: 0=multiply, 1=divide; bit1: 0=unsigned, 1=signed
Operand1  input  WIDTH  multiplicand / dividend
Operand2  input  WIDTH  multiplier / divisor
WA3In  input  4  destination register tag of the requesting instruction
Result1  output  WIDTH  product low half / quotient
Result2  output  WIDTH  product high half / remainder
Busy  output  1  operation in progress
Done  output  1  one-cycle pulse; results valid
MCycleWA3  output  4  tag of the in-flight or last-completed operation

Behaviour:
- Reset: RESETn=0 at a clock edge forces IDLE and clears all outputs: Result1=0, Result2=0, Busy=0, Done=0, MCycleWA3=0.
- Reset mid-operation aborts the operation; no Done is produced.
- States: IDLE, COMPUTE, DONE.
- IDLE/DONE with Start=1:
  - latch operands, MCycleOp and WA3In; MCycleWA3<=WA3In;
  - go to COMPUTE; Busy=1 from the next cycle; iteration counter <=0.
- IDLE/DONE with Start=0: DONE→IDLE. IDLE stays IDLE.
- COMPUTE: one iteration per cycle for exactly WIDTH cycles.
  - Multiply: shift-add on magnitudes.
  - Divide: restoring division on magnitudes.
  - At count WIDTH-1, apply sign fix-ups, register Result1/Result2, go to DONE.
- Latency: Start sampled in cycle N → Busy=1 in cycles N+1..N+WIDTH → Done=1, Busy=0 in cycle N+WIDTH+1.
- Result1/Result2/MCycleWA3 hold until the next accepted Start.
- Start while Busy=1 is ignored: no latch, no restart, operation unaffected.
- Back-to-back: Start in the DONE cycle is accepted; Busy=1 again in the following cycle.
- Signed handling (bit1=1):
  - operands converted to magnitudes;
  - product negated if signs differ;
  - quotient negated if signs differ;
  - remainder takes the sign of the dividend.
- Signed overflow (−2^(WIDTH−1) / −1): quotient=0x80000000, remainder=0 (falls out of magnitude method; required).
- Divide by zero (signed or unsigned):
  - Result1=all ones, Result2=Operand1 unmodified;
  - sign fix-ups suppressed; still takes the full WIDTH cycles.
- Busy and Done are never 1 in the same cycle.
- Done is only ever a single-cycle pulse.

Decomposition:
- Shared package holds:
  - MCycleOp bit encodings (OP_MUL, OP_DIV, OP_SIGNED);
  - state enum {IDLE, COMPUTE, DONE};
  - register-tag width constant (4).
- One natural sub-module: mcycle_signfix, combinational.
  - Inputs: raw magnitude results, operand signs, op, div-by-zero flag.
  - Outputs: final Result1/Result2.
  - Keeps the iteration datapath sign-agnostic.

Test Plan:
- Unsigned mul 7×6, WA3In=5, Start at cycle N → Busy cycles N+1..N+32; Done at N+33; Result1=42, Result2=0, MCycleWA3=5.
- Signed mul −3×5 (0xFFFFFFFD×0x00000005) → Result1=0xFFFFFFF1, Result2=0xFFFFFFFF.
- Unsigned div 100/7 → Result1=14, Result2=2.
- Signed div −7/2 → Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
- Signed div 0x80000000/0xFFFFFFFF → Result1=0x80000000, Result2=0.
- Unsigned div 123/0 → Result1=0xFFFFFFFF, Result2=123 after 32 Busy cycles.
- Robustness:
  - Start re-asserted with new operands while Busy → ignored; original result delivered.
  - RESETn=0 at cycle N+10 → Busy=0 next cycle, no Done, outputs 0.
  - Start in Done cycle → Busy=1 the following cycle.
